uart_rx_ctrl: RTL and testbench

//  Sequencing/config controller for the UART receive datapath. Drives the baud

---
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud period config, rdy/clr_rdy drain into a
// show-ahead byte FIFO, overrun flag and idle-gap interrupt.
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [11:0] DEFAULT_BAUD = 12'hA2B,
    parameter int          IDLE_BITS    = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_err,
    input  logic        err_clr,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rx_valid,
    output logic [6:0]  fifo_count,
    output logic        overrun,
    output logic        idle_irq,
    output logic [31:0] baud_period,
    output logic [31:0] half_baud_period,
    input  logic        uart_rdy,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_clr_rdy
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam int               GAP_W      = $clog2(IDLE_BITS + 1);
    localparam logic [6:0]       DEPTH_CNT  = 7'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(IDLE_BITS);
    localparam logic [11:0]      MIN_PERIOD = 12'd16;
    localparam logic [12:0]      DEF_SUM    = {1'b0, DEFAULT_BAUD} + 13'd1;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [11:0]        period_q, period_d;
    logic [11:0]        half_q, half_d;
    logic               cfg_err_q, cfg_err_d;
    logic               overrun_q, overrun_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [6:0]         count_q, count_d;
    logic [11:0]        bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               armed_q, armed_d;
    logic               irq_q, irq_d;

    logic [7:0]         mem [FIFO_DEPTH];
    logic               push_req;
    logic               fifo_full, fifo_empty, do_pop, do_write;
    logic               cfg_ok, cfg_bad;
    logic [12:0]        half_sum;
    logic               unused_cfg_hi;

    assign unused_cfg_hi = ^cfg_wdata[31:12];

    // Drain handshake: a byte is taken in WAIT, then one HOLD cycle lets the
    // receiver drop rdy before it can be sampled again.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (uart_rdy) begin
                    push_req = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD:  state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    assign uart_clr_rdy = push_req;

    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == 7'd0);
    assign do_pop     = rd_en && !fifo_empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_write   = push_req && (!fifo_full || do_pop);

    assign cfg_ok   = cfg_we && (cfg_wdata[11:0] >= MIN_PERIOD);
    assign cfg_bad  = cfg_we && (cfg_wdata[11:0] < MIN_PERIOD);
    assign half_sum = {1'b0, cfg_wdata[11:0]} + 13'd1;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(do_write);
        rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop);
        count_d   = count_q + 7'(do_write) - 7'(do_pop);

        overrun_d = overrun_q;
        if (err_clr)
            overrun_d = 1'b0;
        if (push_req && fifo_full && !do_pop)
            overrun_d = 1'b1;

        cfg_err_d = cfg_err_q;
        if (err_clr)
            cfg_err_d = 1'b0;
        if (cfg_bad)
            cfg_err_d = 1'b1;

        period_d = cfg_ok ? cfg_wdata[11:0] : period_q;
        half_d   = cfg_ok ? half_sum[12:1]  : half_q;
    end

    // Idle timer: bit-times of silence since the last received byte, only
    // meaningful while unread data sits in the FIFO.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        armed_d   = armed_q;
        irq_d     = 1'b0;
        if (push_req) begin
            bit_cnt_d = 12'd0;
            gap_d     = '0;
            armed_d   = 1'b1;
        end else if (fifo_empty) begin
            bit_cnt_d = 12'd0;
            gap_d     = '0;
        end else begin
            if (cfg_ok) begin
                bit_cnt_d = 12'd0;
            end else if (bit_cnt_q >= period_q) begin
                bit_cnt_d = 12'd0;
                if (gap_q != GAP_MAX)
                    gap_d = gap_q + GAP_W'(1);
            end else begin
                bit_cnt_d = bit_cnt_q + 12'd1;
            end
            if (armed_q && (gap_q == GAP_MAX)) begin
                irq_d   = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT;
            period_q  <= DEFAULT_BAUD;
            half_q    <= DEF_SUM[12:1];
            cfg_err_q <= 1'b0;
            overrun_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 7'd0;
            bit_cnt_q <= 12'd0;
            gap_q     <= '0;
            armed_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            half_q    <= half_d;
            cfg_err_q <= cfg_err_d;
            overrun_q <= overrun_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            bit_cnt_q <= bit_cnt_d;
            gap_q     <= gap_d;
            armed_q   <= armed_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr_q] <= uart_rx_data;
    end

    assign rd_data          = fifo_empty ? 8'h00 : mem[rd_ptr_q];
    assign rx_valid         = !fifo_empty;
    assign fifo_count       = count_q;
    assign overrun          = overrun_q;
    assign cfg_err          = cfg_err_q;
    assign idle_irq         = irq_q;
    assign baud_period      = {20'd0, period_q};
    assign half_baud_period = {20'd0, half_q};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed steps plus a random phase,
// checked against a queue-based reference model of the FIFO and config rules.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        cfg_err;
    logic        err_clr = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rx_valid;
    logic [6:0]  fifo_count;
    logic        overrun;
    logic        idle_irq;
    logic [31:0] baud_period;
    logic [31:0] half_baud_period;
    logic        uart_rdy = 1'b0;
    logic [7:0]  uart_rx_data = 8'd0;
    logic        uart_clr_rdy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mq[$];
    logic        m_overrun;
    logic        m_cfg_err;
    logic [11:0] m_period;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_BAUD(12'hA2B),
        .IDLE_BITS   (40)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .cfg_wdata       (cfg_wdata),
        .cfg_err         (cfg_err),
        .err_clr         (err_clr),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rx_valid        (rx_valid),
        .fifo_count      (fifo_count),
        .overrun         (overrun),
        .idle_irq        (idle_irq),
        .baud_period     (baud_period),
        .half_baud_period(half_baud_period),
        .uart_rdy        (uart_rdy),
        .uart_rx_data    (uart_rx_data),
        .uart_clr_rdy    (uart_clr_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_overrun = 1'b0;
        m_cfg_err = 1'b0;
        m_period  = 12'hA2B;
    endtask

    task automatic check_state();
        logic [7:0] exp_head;
        int         exp_half;
        exp_head = (mq.size() != 0) ? mq[0] : 8'h00;
        exp_half = (int'(m_period) + 1) / 2;
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
        chk("rd_data", 32'(rd_data), 32'(exp_head));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        chk("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
        chk("baud_period", baud_period, 32'(m_period));
        chk("half_baud_period", half_baud_period, 32'(exp_half));
        chk("idle_irq_quiet", 32'(idle_irq), 32'd0);
    endtask

    // One clock of stimulus; the model applies the same cycle's effects.
    task automatic cycle(input logic rdy, input logic [7:0] d, input logic rd,
                         input logic we, input logic [31:0] wd, input logic eclr);
        logic       pop;
        logic [11:0] wlo;
        uart_rdy     = rdy;
        uart_rx_data = d;
        rd_en        = rd;
        cfg_we       = we;
        cfg_wdata    = wd;
        err_clr      = eclr;
        pop          = rd && (mq.size() != 0);
        wlo          = wd[11:0];
        #1;
        chk("clr_rdy", 32'(uart_clr_rdy), 32'(rdy));
        if (pop)
            chk("pop_data", 32'(rd_data), 32'(mq[0]));
        @(posedge clk);
        if (eclr) begin
            m_cfg_err = 1'b0;
            m_overrun = 1'b0;
        end
        if (we) begin
            if (wlo >= 12'd16) m_period = wlo;
            else               m_cfg_err = 1'b1;
        end
        if (pop)
            void'(mq.pop_front());
        if (rdy) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else                   m_overrun = 1'b1;
        end
        #1;
        uart_rdy = 1'b0;
        rd_en    = 1'b0;
        cfg_we   = 1'b0;
        err_clr  = 1'b0;
        if (rdy || pop || we)
            $display("txn t=%0t push=%0b data=%02h pop=%0b cfg=%0b count=%0d",
                     $time, rdy, d, pop, we, fifo_count);
        check_state();
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && mq.size() != 0; i++)
            cycle(1'b0, 8'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        logic        prev_rdy;
        logic        r_rdy, r_rd, r_we, r_eclr;
        logic [31:0] r_wd;
        int          first_n;
        int          extra;

        model_reset();
        #12;
        check_state();
        chk("reset_baud", baud_period, 32'h0000_0A2B);
        chk("reset_half", half_baud_period, 32'h0000_0516);
        chk("reset_clr_rdy", 32'(uart_clr_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // Single byte handshake
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("first_byte_data", 32'(rd_data), 32'h5A);
        chk("first_byte_count", 32'(fifo_count), 32'd1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        drain();

        // Nine bytes into an eight-deep FIFO
        for (int i = 0; i < 9; i++)
            send(8'($urandom));
        chk("overflow_count", 32'(fifo_count), 32'd8);
        chk("overflow_flag", 32'(overrun), 32'd1);
        drain();
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("overrun_cleared", 32'(overrun), 32'd0);

        // Config writes
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_000F, 1'b0);
        chk("bad_cfg_err", 32'(cfg_err), 32'd1);
        chk("bad_cfg_baud", baud_period, 32'h0000_0A2B);
        chk("bad_cfg_half", half_baud_period, 32'h0000_0516);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_0005, 1'b1);
        chk("set_wins_err", 32'(cfg_err), 32'd1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("err_cleared", 32'(cfg_err), 32'd0);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 32'hABCD_E363, 1'b0);
        chk("cfg_363_baud", baud_period, 32'h0000_0363);
        chk("cfg_363_half", half_baud_period, 32'h0000_01B2);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_0010, 1'b0);
        chk("cfg_min_half", half_baud_period, 32'h0000_0008);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_0FFF, 1'b0);
        chk("cfg_max_half", half_baud_period, 32'h0000_0800);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_0363, 1'b0);

        // Push and pop together on a full FIFO
        for (int i = 0; i < DEPTH; i++)
            send(8'($urandom));
        cycle(1'b1, 8'hA7, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("full_pushpop_count", 32'(fifo_count), 32'd8);
        chk("full_pushpop_ovr", 32'(overrun), 32'd0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        drain();

        // Push and pop together on an empty FIFO
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("empty_pushpop_count", 32'(fifo_count), 32'd1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Random traffic
        prev_rdy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            r_rdy  = !prev_rdy && ($urandom_range(0, 2) == 0);
            r_rd   = ($urandom_range(0, 2) == 0);
            r_we   = ($urandom_range(0, 9) == 0);
            r_wd   = $urandom;
            if ($urandom_range(0, 3) == 0)
                r_wd[11:0] = 12'($urandom_range(0, 15));
            r_eclr = ($urandom_range(0, 15) == 0);
            cycle(r_rdy, 8'($urandom), r_rd, r_we, r_wd, r_eclr);
            prev_rdy = r_rdy;
        end
        if (mq.size() == 0)
            send(8'h3C);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Asynchronous reset in the middle of a handshake
        uart_rdy     = 1'b1;
        uart_rx_data = 8'hEE;
        #1;
        chk("pre_reset_clr_rdy", 32'(uart_clr_rdy), 32'd1);
        #2;
        rst_n    = 1'b0;
        uart_rdy = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("async_reset_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // Idle-gap interrupt with the shortest legal period (17 clocks per bit)
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_0010, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0, 32'd0, 1'b0);
        first_n = -1;
        extra   = 0;
        for (int n = 1; n <= 3 * 40 * 17; n++) begin
            @(posedge clk);
            #1;
            if (idle_irq === 1'b1) begin
                if (first_n < 0) first_n = n;
                else             extra++;
            end
        end
        checks++;
        assert (first_n >= 40 * 17 && first_n <= 40 * 17 + 4) else begin
            errors++;
            $error("FAIL idle_irq_time: observed=%0d expected=%0d..%0d",
                   first_n, 40 * 17, 40 * 17 + 4);
        end
        $display("idle txn first_irq_cycle=%0d extra_pulses=%0d", first_n, extra);
        chk("idle_irq_no_repeat", 32'(extra), 32'd0);
        chk("idle_count_kept", 32'(fifo_count), 32'd1);
        chk("idle_head_kept", 32'(rd_data), 32'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
